// File: rtl/uart_shift_reg.sv
// uart_shift_reg: N-bit shift register for the UART datapath.
// Synchronous parallel load, selectable shift direction, serial in/out and a
// saturating shift counter with a done flag. One instance serialises a TX
// frame (dir=0, LSB first) or deserialises an RX frame without external
// counting logic.
module uart_shift_reg #(
    parameter int           N       = 8,
    parameter logic [N-1:0] RST_VAL = {N{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [N-1:0]             d,
    input  logic                     shift_en,
    input  logic                     dir,
    input  logic                     serial_in,
    output logic [N-1:0]             q,
    output logic                     serial_out,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     done
);

    localparam int CW = $clog2(N+1);

    // Count value just before the final shift of a frame; when a shift happens
    // from here, count reaches N and done rises on the same edge.
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [N-1:0] shr;
    logic [N-1:0] shl;

    // Next-value candidates for both shift directions. Written as loops so
    // N=1 works without out-of-range slices (both collapse to serial_in).
    always_comb begin
        shr = '0;
        shl = '0;
        shr[N-1] = serial_in;
        shl[0]   = serial_in;
        for (int i = 0; i < N - 1; i++) begin
            shr[i]   = q[i+1];
            shl[i+1] = q[i];
        end
    end

    // Register update with priority reset > load > shift > hold. done mirrors
    // count == N, so it doubles as the saturation guard for shift_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= RST_VAL;
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            q     <= d;
            count <= '0;
            done  <= 1'b0;
        end else if (shift_en && !done) begin
            q     <= dir ? shl : shr;
            count <= count + CW'(1);
            done  <= (count == LAST_CNT);
        end
    end

    // The bit that leaves on the next shift, following the live dir input.
    assign serial_out = dir ? q[N-1] : q[0];

endmodule

// File: tb/tb_uart_shift_reg.sv
// tb_uart_shift_reg: directed bench for uart_shift_reg with N=8, N=1 and N=12
// instances sharing one control stream. An arithmetic reference model is
// compared against every instance on each falling edge once reset has been
// seen; literal expectations pin the model at the key points of each frame.
module tb_uart_shift_reg;

    // ---------------- clock / reset / stimulus signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b0;
    logic        load      = 1'b0;
    logic        shift_en  = 1'b0;
    logic        dir       = 1'b0;
    logic        serial_in = 1'b0;
    logic [7:0]  d8        = '0;
    logic [11:0] d12       = '0;
    logic [0:0]  d1;
    assign d1 = d8[0:0];

    logic [7:0]  q8;
    logic [3:0]  count8;
    logic        so8, done8;
    logic [0:0]  q1;
    logic [0:0]  count1;
    logic        so1, done1;
    logic [11:0] q12;
    logic [3:0]  count12;
    logic        so12, done12;

    uart_shift_reg #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .load(load), .d(d8), .shift_en(shift_en),
        .dir(dir), .serial_in(serial_in), .q(q8), .serial_out(so8),
        .count(count8), .done(done8)
    );

    uart_shift_reg #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .d(d1), .shift_en(shift_en),
        .dir(dir), .serial_in(serial_in), .q(q1), .serial_out(so1),
        .count(count1), .done(done1)
    );

    uart_shift_reg #(.N(12)) dut12 (
        .clk(clk), .reset(reset), .load(load), .d(d12), .shift_en(shift_en),
        .dir(dir), .serial_in(serial_in), .q(q12), .serial_out(so12),
        .count(count12), .done(done12)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Register value as an integer, shifts as arithmetic on that integer,
    // counter as a plain int that stops at n.
    logic [31:0] m8_q, m1_q, m12_q;
    int          m8_c, m1_c, m12_c;
    bit          model_valid = 1'b0;

    function automatic logic [31:0] mask_of(input int n);
        return (32'h1 << n) - 32'h1;
    endfunction

    function automatic void mstep(input int n, input logic [31:0] dv,
                                  input logic [31:0] qi, input int ci,
                                  output logic [31:0] qo, output int co);
        logic [31:0] m;
        m  = mask_of(n);
        qo = qi;
        co = ci;
        if (reset) begin
            qo = m;
            co = 0;
        end else if (load) begin
            qo = dv & m;
            co = 0;
        end else if (shift_en && ci < n) begin
            if (!dir) qo = (qi >> 1) | (32'(serial_in) << (n - 1));
            else      qo = ((qi << 1) | 32'(serial_in)) & m;
            co = ci + 1;
        end
    endfunction

    always @(posedge clk) begin
        mstep(8,  32'(d8),  m8_q,  m8_c,  m8_q,  m8_c);
        mstep(1,  32'(d1),  m1_q,  m1_c,  m1_q,  m1_c);
        mstep(12, 32'(d12), m12_q, m12_c, m12_q, m12_c);
        if (reset) model_valid = 1'b1;
    end

    function automatic logic model_so(input int n, input logic [31:0] mq);
        return dir ? mq[n-1] : mq[0];
    endfunction

    // Compare process: every falling edge once the model is anchored by reset.
    always @(negedge clk) begin
        if (model_valid) begin
            check("n8_q",      32'(q8),      m8_q);
            check("n8_count",  32'(count8),  32'(m8_c));
            check("n8_done",   32'(done8),   32'(m8_c == 8));
            check("n8_so",     32'(so8),     32'(model_so(8, m8_q)));
            check("n1_q",      32'(q1),      m1_q);
            check("n1_count",  32'(count1),  32'(m1_c));
            check("n1_done",   32'(done1),   32'(m1_c == 1));
            check("n1_so",     32'(so1),     32'(model_so(1, m1_q)));
            check("n12_q",     32'(q12),     m12_q);
            check("n12_count", 32'(count12), 32'(m12_c));
            check("n12_done",  32'(done12),  32'(m12_c == 12));
            check("n12_so",    32'(so12),    32'(model_so(12, m12_q)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; load = 1'b0; shift_en = 1'b0;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); idle();
    endtask

    task automatic do_load(input logic [7:0] v8, input logic [11:0] v12);
        idle(); load = 1'b1; d8 = v8; d12 = v12; tick(); idle();
    endtask

    task automatic do_shift(input logic dr, input logic si);
        idle(); shift_en = 1'b1; dir = dr; serial_in = si; tick(); idle();
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] tx_exp;
    logic [7:0] rx_bits;

    initial begin
        // Reset from an arbitrary, partly shifted state.
        do_load(8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)));
        for (int i = 0; i < 3; i++) do_shift(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        check("rst_q",     32'(q8),     32'hFF);
        check("rst_so",    32'(so8),    32'h1);
        check("rst_count", 32'(count8), 32'h0);
        check("rst_done",  32'(done8),  32'h0);
        tick();
        check("idle_q", 32'(q8), 32'hFF);

        // TX right shift of 0xA5, serial_in held at idle level.
        do_load(8'hA5, 12'h0F0);
        tx_exp = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            shift_en = 1'b1; dir = 1'b0; serial_in = 1'b1;
            #1;
            check("tx_so", 32'(so8), 32'(tx_exp[i]));
            tick(); idle();
        end
        check("tx_q",     32'(q8),     32'hFF);
        check("tx_count", 32'(count8), 32'd8);
        check("tx_done",  32'(done8),  32'h1);

        // RX left shift: 1,1,0,0,1,0,1,0 assembles 0xCA.
        do_load(8'h00, 12'h000);
        rx_bits = 8'hCA;
        for (int i = 0; i < 8; i++) begin
            do_shift(1'b1, rx_bits[7-i]);
            check("rx_done_edge", 32'(done8), 32'(i == 7));
        end
        check("rx_q", 32'(q8), 32'hCA);
        do_shift(1'b1, 1'b1);
        do_shift(1'b0, 1'b0);
        check("rx_sat_q",     32'(q8),     32'hCA);
        check("rx_sat_count", 32'(count8), 32'd8);

        // Load beats shift; reset beats load; load while done restarts.
        idle(); load = 1'b1; shift_en = 1'b1; dir = 1'b0; serial_in = 1'b0;
        d8 = 8'h3C; d12 = 12'h3C3; tick(); idle();
        check("prio_load_q",     32'(q8),     32'h3C);
        check("prio_load_count", 32'(count8), 32'h0);
        idle(); reset = 1'b1; load = 1'b1; d8 = 8'h55; tick(); idle();
        check("prio_rst_q",     32'(q8),     32'hFF);
        check("prio_rst_count", 32'(count8), 32'h0);

        // Mid-frame reset discards the partial frame.
        do_load(8'h81, 12'h801);
        for (int i = 0; i < 3; i++) do_shift(1'b0, 1'b0);
        check("mid_count", 32'(count8), 32'd3);
        check("mid_q",     32'(q8),     32'h10);
        do_reset();
        check("mid_rst_q",     32'(q8),     32'hFF);
        check("mid_rst_count", 32'(count8), 32'h0);
        check("mid_rst_done",  32'(done8),  32'h0);
        do_load(8'h81, 12'h801);
        for (int i = 0; i < 8; i++) do_shift(1'b0, 1'b0);
        check("mid_full_q",    32'(q8),    32'h00);
        check("mid_full_done", 32'(done8), 32'h1);
        do_load(8'h96, 12'h696);
        check("reload_done", 32'(done8), 32'h0);

        // Parameter sweep: 13 shifts with alternating dir, holds in between.
        do_load(8'h01, 12'hA53);
        for (int i = 0; i < 13; i++) begin
            do_shift(1'(i % 2), 1'($urandom_range(0, 1)));
            if (i == 0) begin
                check("n1_done_first", 32'(done1),  32'h1);
                check("n1_count_first", 32'(count1), 32'h1);
            end
            if (i % 4 == 3) tick();
        end
        check("n12_count_sat", 32'(count12), 32'd12);
        check("n12_done_sat",  32'(done12),  32'h1);
        check("n1_count_sat",  32'(count1),  32'h1);
        dir = 1'b1; #1;
        check("n12_so_left", 32'(so12), 32'(q12[11]));
        dir = 1'b0; #1;
        check("n12_so_right", 32'(so12), 32'(q12[0]));
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_shift_reg.md
# uart_shift_reg

Parametrised N-bit shift register for the UART datapath, the successor to the plain N-bit D flip-flop bank. It adds a synchronous parallel load, a selectable shift direction, serial in/out and a shift counter with a done flag. One instance serialises a TX frame or deserialises an RX frame without external counting logic.

## Interface
- N, default 8: register width in bits; legal range N ≥ 1.
- RST_VAL, default {N{1'b1}}: value loaded into q on reset. All ones keeps serial_out at the UART idle level.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  parallel load strobe.
- d  input  N  parallel load data.
- shift_en  input  1  shift strobe, one bit position per cycle.
- dir  input  1  shift direction: 0 = right (LSB out first, UART order), 1 = left (MSB out first).
- serial_in  input  1  bit shifted into the vacated end.
- q  output  N  register contents.
- serial_out  output  1  bit that leaves on the next shift: q[0] when dir=0, q[N-1] when dir=1.
- count  output  $clog2(N+1)  shifts performed since the last load or reset; range 0..N.
- done  output  1  high while count == N.

## Operation
- One clock, one synchronous active-high reset; no asynchronous paths.
- Priority each rising edge: reset > load > shift_en > hold.
- Reset: q = RST_VAL, count = 0, done = 0.
- Load (reset=0, load=1): q = d, count = 0, done = 0. shift_en and dir are ignored that cycle.
- Shift right (shift_en=1, dir=0, count < N): q = {serial_in, q[N-1:1]}, count = count + 1.
- Shift left (shift_en=1, dir=1, count < N): q = {q[N-2:0], serial_in}, count = count + 1. For N=1 both directions give q = serial_in.
- Saturation: when count == N, shift_en is ignored and q, count and done hold. Only load or reset restarts.
- done is a level derived from the registered count reaching N. It stays high until load or reset.
- Hold (no strobe): all state unchanged.
- dir may change between shifts. Each shift uses the dir value sampled on that edge.
- count width is $clog2(N+1) so that N itself is representable. Increment never wraps because of saturation.

## Timing
- q, count and done are registered. They update on the rising edge where the strobe is sampled, so latency is 1 cycle.
- serial_out is combinational from q and dir, with no added latency. The bit visible before edge k is the bit shifted out at edge k.
- done rises on the same edge as the N-th shift. It falls on the edge of the next load or reset.
- Reset asserted mid-sequence (0 < count < N) takes effect on the next edge: q = RST_VAL, count = 0, done = 0. The partial frame is discarded.
- load and shift_en high together: load wins, count = 0, no bit is shifted.
- load while done = 1: the new frame starts immediately, with done low after that edge.
- Out of reset with no strobes: q = RST_VAL, serial_out = 1 (default RST_VAL), count = 0, done = 0.

## Test plan
- Reset: pulse reset for 1 cycle from random state -> q=0xFF, serial_out=1, count=0, done=0 (N=8 default).
- TX right shift: load d=0xA5, then 8 cycles of shift_en=1, dir=0, serial_in=1 -> serial_out sampled before each edge = 1,0,1,0,0,1,0,1; after the 8th edge q=0xFF, count=8, done=1.
- RX left shift: load d=0x00, shift in serial_in = 1,1,0,0,1,0,1,0 with dir=1 -> q=0xCA, done=1 exactly on the 8th edge. Two further shift_en cycles leave q=0xCA and count=8.
- Priority: load=1, d=0x3C, shift_en=1 on the same edge -> q=0x3C, count=0. Then reset=1 with load=1 -> q=0xFF, count=0.
- Mid-frame reset: load 0x81, 3 right shifts (count=3), then reset -> q=0xFF, count=0, done=0. A following load plus 8 shifts completes normally.
- Parameter sweep with N=1 (count width 1) and N=12: N shifts set done, the (N+1)-th shift is ignored, and serial_out tracks dir on each edge.
